// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered result and flags out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/logic/shift ops, iterative shift-add MUL,
// result held in HOLD until the consumer takes it.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               overflow_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [SHW-1:0]     cnt_reg;

    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_o;
    logic [2*WIDTH-1:0] prod_next;
    logic               accept;

    assign shamt   = bus.b[SHW-1:0];
    assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_ext = {1'b0, bus.a} - {1'b0, bus.b};
    // One guard bit on the exit side catches the last bit shifted out (0 when shamt is 0).
    assign shl_ext = {1'b0, bus.a} << shamt;
    assign shr_ext = {bus.a, 1'b0} >> shamt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        case (bus.op)
            3'b000: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_o   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b001: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_o   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010: alu_res = bus.a & bus.b;
            3'b011: alu_res = bus.a | bus.b;
            3'b100: alu_res = bus.a ^ bus.b;
            3'b101: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            3'b110: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: ;
        endcase
    end

    assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

    assign bus.in_ready  = (state_reg == IDLE) && !rst;
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.result    = result_reg;
    assign bus.carry     = carry_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = overflow_reg;
    assign accept        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            result_reg   <= '0;
            carry_reg    <= 1'b0;
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            mcand_reg    <= '0;
            prod_reg     <= '0;
            mplier_reg   <= '0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == 3'b111) begin
                            state_reg  <= MUL;
                            mcand_reg  <= {{WIDTH{1'b0}}, bus.a};
                            mplier_reg <= bus.b;
                            prod_reg   <= '0;
                            cnt_reg    <= '0;
                        end else begin
                            state_reg    <= HOLD;
                            result_reg   <= alu_res;
                            carry_reg    <= alu_c;
                            overflow_reg <= alu_o;
                            zero_reg     <= (alu_res == '0);
                        end
                    end
                end
                MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    // Last of WIDTH iterations: publish the final partial sum directly.
                    if (cnt_reg == SHW'(WIDTH - 1)) begin
                        state_reg    <= HOLD;
                        result_reg   <= prod_next[WIDTH-1:0];
                        carry_reg    <= |prod_next[2*WIDTH-1:WIDTH];
                        overflow_reg <= 1'b0;
                        zero_reg     <= (prod_next[WIDTH-1:0] == '0);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
